// File: rtl/alu_issue_queue_if.sv
// Upstream op handshake between an instruction source and the ALU issue queue.
// The master side offers ops and the slave side (the queue) returns in_ready.
interface alu_issue_queue_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [1:0] in_inst;
  logic       in_clr;

  modport master (output in_valid, output in_a, output in_inst, output in_clr, input in_ready);
  modport slave  (input in_valid, input in_a, input in_inst, input in_clr, output in_ready);
endinterface

// File: rtl/alu_issue_queue.sv
// FIFO of ALU ops that issues at most one op per cycle into registered ALU controls.
// Idle cycles issue an add-zero NOP so the downstream accumulator holds its value.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     RESET_N,
  alu_issue_queue_if.slave         up,
  input  logic                     halt,
  input  logic                     flush,
  output logic [3:0]               issue_a,
  output logic [1:0]               issue_inst,
  output logic                     issue_rst,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_C    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   OCC_ZERO_C = (PTR_W + 1)'(0);
  localparam logic [PTR_W:0]   OCC_ONE_C  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO_C = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);

  typedef struct packed {
    logic [3:0] a;
    logic [1:0] inst;
    logic       clr;
  } entry_t;

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic [PTR_W:0]   occ_r, occ_s;
  logic             push_s, pop_s;
  entry_t           head_s;
  logic [3:0]       issue_a_s;
  logic [1:0]       issue_inst_s;
  logic             issue_rst_s;
  logic             issue_valid_s;

  // Handshake: readiness never accounts for a same-cycle pop.
  always_comb begin
    up.in_ready = (occ_r != FULL_C) && !flush;
    push_s      = up.in_valid && up.in_ready;
    pop_s       = (occ_r != OCC_ZERO_C) && !halt && !flush;
    head_s      = mem_r[rd_ptr_r];
  end

  // Pointer and occupancy next state; flush overrides everything.
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    occ_s    = occ_r;
    if (flush) begin
      wr_ptr_s = PTR_ZERO_C;
      rd_ptr_s = PTR_ZERO_C;
      occ_s    = OCC_ZERO_C;
    end else begin
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE_C;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE_C;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   occ_s = occ_r + OCC_ONE_C;
        2'b01:   occ_s = occ_r - OCC_ONE_C;
        default: occ_s = occ_r;
      endcase
    end
  end

  // Issue register next values: popped entry, clear op, or NOP.
  always_comb begin
    issue_a_s     = 4'd0;
    issue_inst_s  = 2'b00;
    issue_rst_s   = 1'b0;
    issue_valid_s = 1'b0;
    if (pop_s) begin
      issue_valid_s = 1'b1;
      if (head_s.clr) begin
        issue_rst_s = 1'b1;
      end else begin
        issue_a_s    = head_s.a;
        issue_inst_s = head_s.inst;
      end
    end else begin
      issue_valid_s = 1'b0;
    end
  end

  // Entry storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_t'({up.in_a, up.in_inst, up.in_clr});
    end
  end

  // Control state; reset holds the ALU accumulator cleared via issue_rst.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r    <= PTR_ZERO_C;
      rd_ptr_r    <= PTR_ZERO_C;
      occ_r       <= OCC_ZERO_C;
      issue_a     <= 4'd0;
      issue_inst  <= 2'b00;
      issue_rst   <= 1'b1;
      issue_valid <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      occ_r       <= occ_s;
      issue_a     <= issue_a_s;
      issue_inst  <= issue_inst_s;
      issue_rst   <= issue_rst_s;
      issue_valid <= issue_valid_s;
    end
  end

  assign occupancy = occ_r;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: a queue-based reference model predicts each
// issued op, and a posedge monitor compares whatever the DUT issues against it.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic       halt = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] issue_a;
  logic [1:0] issue_inst;
  logic       issue_rst;
  logic       issue_valid;
  logic [2:0] occupancy;

  alu_issue_queue_if up ();

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .RESET_N(RESET_N), .up(up), .halt(halt), .flush(flush),
    .issue_a(issue_a), .issue_inst(issue_inst), .issue_rst(issue_rst),
    .issue_valid(issue_valid), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] a; logic [1:0] inst; logic clr; } op_t;
  typedef struct { logic [3:0] a; logic [1:0] inst; logic rst; } iss_t;

  op_t  model_q [$];
  iss_t exp_q [$];
  logic exp_valid = 1'b0;
  int   exp_occ = 0;
  logic mon_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: drive at negedge, check in_ready, advance the model.
  task automatic step(input logic v, input logic [3:0] a, input logic [1:0] inst,
                      input logic clr, input logic h, input logic f);
    logic rdy;
    op_t  e;
    iss_t x;
    @(negedge clk);
    up.in_valid = v; up.in_a = a; up.in_inst = inst; up.in_clr = clr;
    halt = h; flush = f;
    #1;
    rdy = (model_q.size() != DEPTH) && !f;
    chk("in_ready", up.in_ready, rdy);
    exp_valid = 1'b0;
    if (f) begin
      model_q.delete();
    end else begin
      if (model_q.size() > 0 && !h) begin
        e = model_q.pop_front();
        x.a = e.clr ? 4'd0 : e.a;
        x.inst = e.clr ? 2'b00 : e.inst;
        x.rst = e.clr;
        exp_q.push_back(x);
        exp_valid = 1'b1;
      end
      if (v && rdy) begin
        e.a = a; e.inst = inst; e.clr = clr;
        model_q.push_back(e);
      end
    end
    exp_occ = model_q.size();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare the issue registers and occupancy after every rising edge.
  initial begin
    iss_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("issue_valid", issue_valid, exp_valid);
        chk("occupancy", occupancy, exp_occ);
        if (issue_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_issue: got a=%0h inst=%0h rst=%0b expected none", issue_a, issue_inst, issue_rst);
          end else begin
            e = exp_q.pop_front();
            chk("issue_a", issue_a, e.a);
            chk("issue_inst", issue_inst, e.inst);
            chk("issue_rst", issue_rst, e.rst);
          end
        end else begin
          chk("nop_fields", {issue_a, issue_inst, issue_rst}, 32'd0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    up.in_valid = 1'b0; up.in_a = 4'd0; up.in_inst = 2'b00; up.in_clr = 1'b0;
    #12;
    chk("reset_issue_rst", issue_rst, 1'b1);
    chk("reset_issue_valid", issue_valid, 1'b0);
    chk("reset_occupancy", occupancy, 3'd0);
    chk("reset_issue_a", issue_a, 4'd0);
    @(negedge clk);
    RESET_N = 1'b1;
    mon_en = 1'b1;
    #1;
    chk("ready_after_reset", up.in_ready, 1'b1);

    // Single op, then fill under halt with a fifth op refused.
    step(1'b1, 4'd3, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 8), 2'(i), 1'b0, 1'b1, 1'b0);
    idle(6);

    // Clear entry between two adds.
    step(1'b1, 4'd7, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Flush with three queued and a concurrent push.
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 1), 2'b01, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'hf, 2'b11, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Full queue with simultaneous pop, then a wrapping stream.
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 4), 2'b10, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 2'(i), 1'b0, 1'b0, 1'b0);
    idle(6);

    // Asynchronous reset between edges with two queued entries.
    for (int i = 0; i < 2; i++) step(1'b1, 4'(i + 10), 2'b00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    up.in_valid = 1'b0; halt = 1'b0; flush = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    chk("async_issue_rst", issue_rst, 1'b1);
    chk("async_issue_valid", issue_valid, 1'b0);
    chk("async_occupancy", occupancy, 3'd0);
    #1 RESET_N = 1'b1;
    model_q.delete();
    exp_valid = 1'b0;
    exp_occ = 0;
    step(1'b1, 4'd6, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 19) == 0);
    end
    idle(8);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter DEPTH, 4, number of FIFO entries (power of two, at least 2).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock, shared with the downstream ALU.
REQ-004 RESET_N  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream op valid.
REQ-006 in_ready  output  1  queue can accept an op.
REQ-007 in_a  input  4  operand for the ALU A input.
REQ-008 in_inst  input  2  ALU opcode: 00 add, 01 sub, 10 mul, 11 xnor.
REQ-009 in_clr  input  1  entry is an accumulator-clear op, not an arithmetic op.
REQ-010 halt  input  1  freezes issue; the queue keeps its contents.
REQ-011 flush  input  1  discards all queued entries.
REQ-012 issue_a  output  4  registered; drives ALU A.
REQ-013 issue_inst  output  2  registered; drives ALU Inst.
REQ-014 issue_rst  output  1  registered; drives the ALU synchronous active-high RESET.
REQ-015 issue_valid  output  1  registered; issue_* carries a real op this cycle.
REQ-016 occupancy  output  log2(DEPTH)+1  number of queued entries, 0..DEPTH.

Function
REQ-017 in_ready SHALL equal (occupancy != DEPTH) AND NOT flush.
- It is derived from registered state only.
- It does not consider a same-cycle pop.
REQ-018 A push SHALL occur at a rising edge when in_valid and in_ready are both 1.
- The entry stored is {in_a, in_inst, in_clr}.
REQ-019 A pop SHALL occur at a rising edge when occupancy != 0, halt = 0 and flush = 0.
- The head entry is loaded into the issue registers.
- issue_valid is set to 1.
REQ-020 The issue register load from a popped entry SHALL be as follows.
- Normal entry: issue_a = entry a, issue_inst = entry inst, issue_rst = 0.
- Clear entry: issue_a = 0, issue_inst = 00, issue_rst = 1.
REQ-021 At any edge without a pop, the issue registers SHALL load the NOP: issue_a = 0, issue_inst = 00, issue_rst = 0, issue_valid = 0.
- The ALU then adds zero, so the accumulator holds its value.
REQ-022 There SHALL be no bypass.
- An op pushed at edge k is issued no earlier than edge k+1.
- Its ALU result registers at edge k+2.
REQ-023 A push and a pop at the same edge SHALL leave occupancy unchanged and preserve FIFO order.
REQ-024 flush = 1 at an edge SHALL do all of the following.
- Set occupancy to 0.
- Reset the read and write pointers.
- Load the NOP into the issue registers.
- Take priority over push, pop and halt.
REQ-025 halt = 1 SHALL block pops only; pushes are still accepted while occupancy < DEPTH.
REQ-026 Pointers SHALL wrap modulo DEPTH.
- occupancy SHALL never exceed DEPTH or underflow below 0.
REQ-027 Ops SHALL issue in strict arrival order, at most one per cycle.
REQ-028 Sustained throughput SHALL be one op per cycle when halt = 0 and the upstream keeps in_valid = 1.

Reset
REQ-029 While RESET_N = 0, the registers SHALL hold the following values.
- occupancy = 0 and both pointers = 0.
- issue_a = 0, issue_inst = 00, issue_valid = 0.
- issue_rst = 1, which holds the ALU accumulator cleared.
REQ-030 Reset assertion SHALL take effect immediately, without waiting for a clock edge.
- It discards queued entries mid-operation.
REQ-031 After RESET_N deasserts, the first rising edge SHALL load the NOP, dropping issue_rst to 0.
- in_ready is 1 from deassertion onward.
REQ-032 FIFO storage contents need not be reset.
- Only the pointers, occupancy and issue registers are reset.

Verification
REQ-033 Reset then single op: push {a=3, add} at edge 1 -> issue_a=3, issue_inst=00, issue_valid=1 after edge 2 -> ALU OUT=3 after edge 3.
REQ-034 Fill with halt=1: push 5 ops -> in_ready=0 after the 4th, occupancy=4, the 5th is not accepted; release halt -> 4 ops issue on 4 consecutive edges in order, then NOP.
REQ-035 Clear entry: queue {a=7, add}, {clr}, {a=2, add} -> issue_rst=1 on the second issue cycle only; ALU OUT sequence 7, 0, 2.
REQ-036 Flush with occupancy=3 and in_valid=1 -> next edge: occupancy=0, issue_valid=0, the pushed op is dropped (in_ready was 0).
REQ-037 Full with simultaneous pop: occupancy=4, halt=0, in_valid=1 -> in_ready=0; after one edge occupancy=3; pointer wrap verified over 10 streaming ops with no loss or reorder.
REQ-038 Async reset mid-stream: drop RESET_N between edges with occupancy=2 -> outputs reach reset values immediately (issue_rst=1); after release no stale entries issue.
